add_pipe: RTL

Parametrised, pipelined two's-complement adder/subtractor and the successor to the fixed 16-bit combinational ADDER. The WIDTH-bit operation is split into STAGES = WIDTH/CHUNK chunk-wide ripple segments, one register stage each. This breaks the long carry chain for use on faster clocks. A valid/ready handshake on both sides accepts one operation per cycle and propagates back-pressure. The ALU datapath uses it where a single-cycle 16-bit ripple adder no longer meets timing.

---
 rtl/add_pipe.sv | 115 +++++++++++
 1 files changed

// File: rtl/add_pipe.sv
// Pipelined two's-complement adder/subtractor: WIDTH/CHUNK ripple segments, one
// register stage each, with a global valid/ready advance that stalls all stages together.
module add_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Handshake: a transfer happens on either side when valid && ready at a rising edge.
  // adv = !out_valid || out_ready moves every stage at once; in_ready mirrors adv.

  // Per-stage registers: operand skew (a_q, b_q), partial sum with deskewed low chunks
  // (s_q), ripple carry out of the stage's chunk (c_q) and the stage valid bit (v_q).
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];

  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic             v_d [STAGES];

  // Operands and carry-in seen by each stage's adder segment.
  logic [WIDTH-1:0] op_a  [STAGES];
  logic [WIDTH-1:0] op_b  [STAGES];
  logic             cin   [STAGES];
  logic [CHUNK:0]   chunk [STAGES];

  logic ovf_q, zero_q, neg_q;
  logic ovf_d, zero_d, neg_d;
  logic adv;

  always_comb begin
    adv     = !v_q[LAST] || out_ready;
    op_a[0] = a;
    op_b[0] = sub ? ~b : b;
    cin[0]  = sub;
    s_d[0]  = '0;
    v_d[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      op_a[k] = a_q[k-1];
      op_b[k] = b_q[k-1];
      cin[k]  = c_q[k-1];
      s_d[k]  = s_q[k-1];
      v_d[k]  = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, op_a[k][k*CHUNK +: CHUNK]} + {1'b0, op_b[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, cin[k]};
      s_d[k][k*CHUNK +: CHUNK] = chunk[k][CHUNK-1:0];
      c_d[k] = chunk[k][CHUNK];
      a_d[k] = op_a[k];
      b_d[k] = op_b[k];
    end
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    ovf_d  = c_d[LAST] ^ (op_a[LAST][WIDTH-1] ^ op_b[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1]);
    zero_d = (s_d[LAST] == '0);
    neg_d  = s_d[LAST][WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
        c_q[k] <= c_d[k];
        v_q[k] <= v_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = v_q[LAST];
  assign sum       = s_q[LAST];
  assign carry     = c_q[LAST];
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule
